// File: rtl/lsu_pkg.sv
// Shared types and memory-map constants for the load/store unit.
// The constants mirror the data_memory globals.
package lsu_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int MEM_ADDR_WIDTH = 10;
  localparam int ROM_DEPTH      = 256;
  localparam int RAM_DEPTH      = 256;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } mem_size_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_RESP    = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling for one memory word.
// Produces the extended load value and the store word merged into the read word.
module lsu_lane_align #(
  parameter int DATA_WIDTH = lsu_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] mem_word_i,
  input  logic [1:0]            lane_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic [DATA_WIDTH-1:0] merge_data_o
);
  import lsu_pkg::*;

  logic [4:0]            shamt_s;
  logic [DATA_WIDTH-1:0] shifted_s;
  logic [DATA_WIDTH-1:0] mask_s;
  logic [DATA_WIDTH-1:0] insert_s;

  assign shamt_s   = {lane_i, 3'b000};
  assign shifted_s = mem_word_i >> shamt_s;

  // Extract/extend the addressed lane and build the write mask for a merge.
  always_comb begin
    load_data_o = shifted_s;
    mask_s      = {DATA_WIDTH{1'b1}};
    insert_s    = wdata_i;
    case (size_i)
      SIZE_B: begin
        load_data_o = unsigned_i ? {{(DATA_WIDTH-8){1'b0}}, shifted_s[7:0]}
                                 : {{(DATA_WIDTH-8){shifted_s[7]}}, shifted_s[7:0]};
        mask_s      = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << shamt_s;
        insert_s    = {{(DATA_WIDTH-8){1'b0}}, wdata_i[7:0]} << shamt_s;
      end
      SIZE_H: begin
        load_data_o = unsigned_i ? {{(DATA_WIDTH-16){1'b0}}, shifted_s[15:0]}
                                 : {{(DATA_WIDTH-16){shifted_s[15]}}, shifted_s[15:0]};
        mask_s      = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << shamt_s;
        insert_s    = {{(DATA_WIDTH-16){1'b0}}, wdata_i[15:0]} << shamt_s;
      end
      default: begin
        load_data_o = shifted_s;
        mask_s      = {DATA_WIDTH{1'b1}};
        insert_s    = wdata_i;
      end
    endcase
    merge_data_o = (mem_word_i & ~mask_s) | (insert_s & mask_s);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one byte/half/word request at a time against data_memory's word port.
// Sub-word stores are read-modify-write because the memory has no byte enables.
module load_store_unit #(
  parameter int DATA_WIDTH     = lsu_pkg::DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = lsu_pkg::MEM_ADDR_WIDTH,
  parameter int ROM_DEPTH      = lsu_pkg::ROM_DEPTH,
  parameter int RAM_DEPTH      = lsu_pkg::RAM_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [31:0]               req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_fault,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]     mem_w_data,
  output logic                      mem_ctrl_w,
  output logic                      mem_ctrl_r,
  input  logic [DATA_WIDTH-1:0]     mem_r_data
);
  import lsu_pkg::*;

  localparam logic [31:0] WORD_LIMIT = 32'(ROM_DEPTH + RAM_DEPTH);
  localparam logic [31:0] ROM_LIMIT  = 32'(ROM_DEPTH);

  lsu_state_t                state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] word_q, word_d;
  logic [1:0]                lane_q, lane_d;
  logic [1:0]                size_q, size_d;
  logic                      we_q, we_d;
  logic                      uns_q, uns_d;
  logic                      fault_q, fault_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

  logic [MEM_ADDR_WIDTH-1:0] req_word_s;
  logic [31:0]               req_word_ext_s;
  logic                      fault_s;
  logic [DATA_WIDTH-1:0]     load_data_s;
  logic [DATA_WIDTH-1:0]     merge_data_s;

  assign req_word_s     = req_addr[MEM_ADDR_WIDTH+1:2];
  assign req_word_ext_s = {{(32-MEM_ADDR_WIDTH){1'b0}}, req_word_s};

  // Writes at word ROM_DEPTH are dropped by data_memory, hence <= rather than <.
  always_comb begin
    fault_s = (req_size == 2'b11)
            | ((req_size == SIZE_H) & req_addr[0])
            | ((req_size == SIZE_W) & (req_addr[1:0] != 2'b00))
            | (|req_addr[31:MEM_ADDR_WIDTH+2])
            | (req_word_ext_s >= WORD_LIMIT)
            | (req_we & (req_word_ext_s <= ROM_LIMIT));
  end

  lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .mem_word_i   (mem_r_data),
    .lane_i       (lane_q),
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data_s),
    .merge_data_o (merge_data_s)
  );

  // Next-state and request-register update.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    lane_d  = lane_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    fault_d = fault_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          word_d  = req_word_s;
          lane_d  = req_addr[1:0];
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          fault_d = fault_s;
          wdata_d = req_wdata;
          if (fault_s) begin
            state_d = S_RESP;
          end else if (req_we && (req_size == SIZE_W)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (we_q) begin
          wdata_d = merge_data_s;
          state_d = S_WRITE;
        end else begin
          rdata_d = load_data_s;
          state_d = S_RESP;
        end
      end
      S_WRITE:   state_d = S_RESP;
      S_RESP: begin
        rdata_d = {DATA_WIDTH{1'b0}};
        fault_d = 1'b0;
        state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // State and request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      word_q  <= {MEM_ADDR_WIDTH{1'b0}};
      lane_q  <= 2'b00;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      wdata_q <= {DATA_WIDTH{1'b0}};
      rdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      fault_q <= fault_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_fault  = (state_q == S_RESP) & fault_q;
  assign resp_rdata  = rdata_q;
  assign mem_ctrl_r  = (state_q == S_READ);
  assign mem_ctrl_w  = (state_q == S_WRITE);
  assign mem_w_data  = (state_q == S_WRITE) ? wdata_q : {DATA_WIDTH{1'b0}};
  assign mem_address = ((state_q == S_READ) || (state_q == S_CAPTURE) || (state_q == S_WRITE))
                       ? word_q : {MEM_ADDR_WIDTH{1'b0}};

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural data_memory model.
// Stimulus pushes expected responses; a negedge monitor pops and compares them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [9:0]  mem_address;
  logic [31:0] mem_w_data;
  logic        mem_ctrl_w;
  logic        mem_ctrl_r;
  logic [31:0] mem_r_data;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_address  (mem_address),
    .mem_w_data   (mem_w_data),
    .mem_ctrl_w   (mem_ctrl_w),
    .mem_ctrl_r   (mem_ctrl_r),
    .mem_r_data   (mem_r_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          nr;
    int          nw;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          n_r = 0;
  int          n_w = 0;
  logic        addr_bad = 1'b0;
  logic [9:0]  cur_word = 10'd0;
  logic        prev_resp = 1'b0;
  logic [31:0] mem [0:1023];

  // data_memory model: registered read, writes at word <= 256 dropped
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_ctrl_r) mem_r_data <= mem[mem_address];
    if (mem_ctrl_w && (mem_address > 10'd256)) mem[mem_address] <= mem_w_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: counts strobes per request and scores each response pulse.
  always @(negedge clk) begin
    exp_t e;
    if (mem_ctrl_r) n_r++;
    if (mem_ctrl_w) n_w++;
    if ((mem_ctrl_r || mem_ctrl_w) && (mem_address != cur_word)) addr_bad = 1'b1;
    if (prev_resp) begin
      chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
      chk("rdata_cleared", resp_rdata, 32'd0);
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", resp_rdata, e.rdata);
        chk("fault", {31'd0, resp_fault}, {31'd0, e.fault});
        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        chk("rd_strobes", 32'(n_r), 32'(e.nr));
        chk("wr_strobes", 32'(n_w), 32'(e.nw));
        chk("mem_addr", {31'd0, addr_bad}, 32'd0);
      end
    end
    prev_resp = resp_valid;
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] erd, input logic ef,
                       input int elat, input int enr, input int enw);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    e.rdata = erd; e.fault = ef; e.lat = elat; e.nr = enr; e.nw = enw; e.acc = cyc;
    exp_q.push_back(e);
    n_r = 0; n_w = 0; addr_bad = 1'b0; cur_word = addr[11:2];
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int t;
    for (int i = 0; i < 1024; i++) mem[i] = (i < 256) ? (32'hC0DE_0000 | 32'(i)) : 32'd0;
    mem_r_data = 32'd0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    #2 rst = 1'b0;

    // reset holds off a pending request
    req_valid = 1'b1; req_addr = 32'h404;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mem_r", {31'd0, mem_ctrl_r}, 32'd0);
      chk("rst_mem_w", {31'd0, mem_ctrl_w}, 32'd0);
      chk("rst_mem_addr", {22'd0, mem_address}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
    end
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_rdata", resp_rdata, 32'd0);

    // word store then load in RAM
    issue(1'b1, 2'b10, 1'b0, 32'h404, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, 0);
    chk("mem257", mem[257], 32'hDEADBEEF);

    // sub-word store and lane extraction
    issue(1'b1, 2'b10, 1'b0, 32'h408, 32'h11223344, 32'h0, 1'b0, 2, 0, 1);
    issue(1'b1, 2'b00, 1'b0, 32'h409, 32'hFFFF_FFAA, 32'h0, 1'b0, 4, 1, 1);
    issue(1'b0, 2'b00, 1'b0, 32'h409, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 1, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h409, 32'h0, 32'h000000AA, 1'b0, 3, 1, 0);
    issue(1'b0, 2'b01, 1'b0, 32'h40A, 32'h0, 32'h00001122, 1'b0, 3, 1, 0);
    issue(1'b0, 2'b01, 1'b0, 32'h408, 32'h0, 32'hFFFFAA44, 1'b0, 3, 1, 0);
    issue(1'b0, 2'b01, 1'b1, 32'h408, 32'h0, 32'h0000AA44, 1'b0, 3, 1, 0);
    issue(1'b1, 2'b01, 1'b0, 32'h40A, 32'h0000_BEEF, 32'h0, 1'b0, 4, 1, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h408, 32'h0, 32'hBEEFAA44, 1'b0, 3, 1, 0);
    chk("mem258", mem[258], 32'hBEEFAA44);

    // alignment, size and range faults
    issue(1'b0, 2'b01, 1'b0, 32'h403, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h406, 32'h1234, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b0, 2'b11, 1'b0, 32'h404, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h1404, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0, 32'h0, 1'b0, 3, 1, 0);

    // ROM protection
    issue(1'b1, 2'b10, 1'b0, 32'h010, 32'h5555AAAA, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h400, 32'h5555AAAA, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 32'hC0DE0004, 1'b0, 3, 1, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'hC0DE0000 & 32'h0, 1'b0, 3, 1, 0);

    // reset during the write phase of a sub-word store
    issue(1'b1, 2'b10, 1'b0, 32'h40C, 32'h12345678, 32'h0, 1'b0, 2, 0, 1);
    issue(1'b1, 2'b00, 1'b0, 32'h40C, 32'h00000055, 32'h0, 1'b0, 4, 1, 1);
    t = 0;
    while (!mem_ctrl_w && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("reached_write", {31'd0, mem_ctrl_w}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_w", {31'd0, mem_ctrl_w}, 32'd0);
    chk("rst_mid_wdata", mem_w_data, 32'd0);
    chk("rst_mid_addr", {22'd0, mem_address}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mem259_kept", mem[259], 32'h12345678);
    chk("rst_rel_ready", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 2'b10, 1'b0, 32'h40C, 32'h0, 32'h12345678, 1'b0, 3, 1, 0);

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
